writeback_scheduler: RTL and testbench

Sequencing controller for the register-file writeback path of the multicycle MIPS datapath. It accepts one writeback request at a time from the main control unit and waits until the selected result source is valid (memory data, shifter, HI/LO). It then drives the writeback-mux select (`MemtoReg`), the destination register and a single-cycle `RegWrite` pulse. Invalid source codes and sources that never become ready are reported instead of written.

---
 rtl/writeback_scheduler.sv | 147 ++++++++++++++
 tb/tb_writeback_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_scheduler.sv
// ---------------------------------------------------------------------------
// writeback_scheduler
// Sequences register-file writebacks for the multicycle MIPS datapath.
// Accepts one request at a time, waits for the selected result source to
// become valid, then drives the writeback-mux select, the destination
// register and a one-cycle RegWrite pulse. Illegal source codes and sources
// that stay not-ready for TIMEOUT cycles end in a one-cycle wb_err pulse.
//
// Ports
//   clk, reset          clock, async active-high reset
//   wb_req/wb_src/wb_dst request (level), source code, destination reg
//   flush               synchronous abort from the control unit
//   mem_ready           MDR valid (sources 0-2)
//   shift_done          shifter result valid (source 3)
//   muldiv_busy         HI/LO not yet valid (sources 4-5)
//   wb_ack              combinational request accept
//   busy                high outside IDLE
//   MemtoReg, WriteReg  captured mux select / write address
//   RegWrite            write enable pulse (suppressed for $zero)
//   wb_done, wb_err     completion / abort pulses
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | request captured, waiting for the source to become valid
// WRITE | one-cycle register-file write
// ERR   | one-cycle error report (illegal source or timeout)
// ---------------------------------------------------------------------------
module writeback_scheduler #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_req,
   input  logic [3:0] wb_src,
   input  logic [4:0] wb_dst,
   input  logic       flush,
   input  logic       mem_ready,
   input  logic       shift_done,
   input  logic       muldiv_busy,
   output logic       wb_ack,
   output logic       busy,
   output logic [3:0] MemtoReg,
   output logic [4:0] WriteReg,
   output logic       RegWrite,
   output logic       wb_done,
   output logic       wb_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_WRITE = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [3:0] memtoreg_q, memtoreg_d;
   logic [4:0] writereg_q, writereg_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       regwrite_q, regwrite_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       ready;

   // Illegal codes never reach WAIT, so the default arm only covers 6-11.
   always_comb begin
      ready = 1'b1;
      case (memtoreg_q)
         4'd0, 4'd1, 4'd2: ready = mem_ready;
         4'd3:             ready = shift_done;
         4'd4, 4'd5:       ready = ~muldiv_busy;
         default:          ready = 1'b1;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      memtoreg_d = memtoreg_q;
      writereg_d = writereg_q;
      wait_cnt_d = wait_cnt_q;
      wb_ack     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Reset gating keeps ack low while the flops are held in reset.
            wb_ack = wb_req & ~flush & ~reset;
            if (wb_ack) begin
               memtoreg_d = wb_src;
               writereg_d = wb_dst;
               wait_cnt_d = 8'd0;
               state_d    = (wb_src >= 4'd12) ? S_ERR : S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush)
               state_d = S_IDLE;
            else if (ready)
               state_d = S_WRITE;
            else if (wait_cnt_q == WAIT_LAST)
               state_d = S_ERR;
            else if (wait_cnt_q != 8'hFF)
               wait_cnt_d = wait_cnt_q + 8'd1;
         end
         S_WRITE: state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pulses are decoded from the next state so they are true flop outputs
   // aligned with the WRITE/ERR cycle.
   always_comb begin
      regwrite_d = (state_d == S_WRITE) && (writereg_d != 5'd0);
      done_d     = (state_d == S_WRITE);
      err_d      = (state_d == S_ERR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         memtoreg_q <= 4'd0;
         writereg_q <= 5'd0;
         wait_cnt_q <= 8'd0;
         regwrite_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         memtoreg_q <= memtoreg_d;
         writereg_q <= writereg_d;
         wait_cnt_q <= wait_cnt_d;
         regwrite_q <= regwrite_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign MemtoReg = memtoreg_q;
   assign WriteReg = writereg_q;
   assign RegWrite = regwrite_q;
   assign wb_done  = done_q;
   assign wb_err   = err_q;

endmodule

// File: tb/tb_writeback_scheduler.sv
module tb_writeback_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       wb_req;
   logic [3:0] wb_src;
   logic [4:0] wb_dst;
   logic       flush;
   logic       mem_ready;
   logic       shift_done;
   logic       muldiv_busy;
   logic       wb_ack;
   logic       busy;
   logic [3:0] MemtoReg;
   logic [4:0] WriteReg;
   logic       RegWrite;
   logic       wb_done;
   logic       wb_err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int ack_cyc;

   typedef struct {
      bit         is_err;
      bit         rw;
      logic [3:0] src;
      logic [4:0] dst;
      int         at;
   } exp_t;

   exp_t sb[$];

   writeback_scheduler #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src),
      .wb_dst(wb_dst), .flush(flush), .mem_ready(mem_ready),
      .shift_done(shift_done), .muldiv_busy(muldiv_busy), .wb_ack(wb_ack),
      .busy(busy), .MemtoReg(MemtoReg), .WriteReg(WriteReg),
      .RegWrite(RegWrite), .wb_done(wb_done), .wb_err(wb_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Scoreboard: every RegWrite/wb_done/wb_err pulse must match the oldest
   // expected completion, including the cycle it lands in.
   always @(negedge clk) begin
      if (!reset && (RegWrite || wb_done || wb_err)) begin
         if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_pulse cyc=%0d RegWrite=%b wb_done=%b wb_err=%b", cyc, RegWrite, wb_done, wb_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (cyc !== e.at) begin errors++; $display("FAIL pulse_cycle got=%0d exp=%0d", cyc, e.at); end
            checks++;
            if (wb_err !== e.is_err || wb_done !== !e.is_err) begin
               errors++; $display("FAIL pulse_kind got done=%b err=%b exp_err=%b", wb_done, wb_err, e.is_err);
            end
            checks++;
            if (RegWrite !== e.rw) begin errors++; $display("FAIL regwrite got=%b exp=%b", RegWrite, e.rw); end
            checks++;
            if (MemtoReg !== e.src || WriteReg !== e.dst) begin
               errors++; $display("FAIL pulse_regs got src=%0d dst=%0d exp src=%0d dst=%0d", MemtoReg, WriteReg, e.src, e.dst);
            end
         end
      end
   end

   // Drive a request at a negedge; lat < 0 means no completion is expected.
   task automatic drive_req(input logic [3:0] s, input logic [4:0] d,
                            input bit is_err, input bit rw, input int lat);
      exp_t e;
      @(negedge clk);
      wb_req = 1'b1; wb_src = s; wb_dst = d;
      ack_cyc = cyc;
      if (lat >= 0) begin
         e.is_err = is_err; e.rw = rw; e.src = s; e.dst = d; e.at = cyc + lat;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk); #2;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; wb_req = 1'b1; wb_src = 4'd6; wb_dst = 5'd8;
      flush = 1'b0; mem_ready = 1'b0; shift_done = 1'b0; muldiv_busy = 1'b0;
      #1;
      checks++;
      if (wb_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", wb_ack); end
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, MemtoReg, WriteReg, RegWrite, wb_done, wb_err} !== 13'd0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=0", {busy, MemtoReg, WriteReg, RegWrite, wb_done, wb_err});
      end
      wb_req = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_immediate();
      drive_req(4'd6, 5'd8, 1'b0, 1'b1, 2);
      #1;
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL imm_ack got=%b exp=1", wb_ack); end
      @(negedge clk);
      wb_req = 1'b0;
      checks++;
      if (MemtoReg !== 4'd6 || WriteReg !== 5'd8 || busy !== 1'b1) begin
         errors++; $display("FAIL imm_capture got src=%0d dst=%0d busy=%b exp 6 8 1", MemtoReg, WriteReg, busy);
      end
      drain();
   endtask

   task automatic test_mem_wait();
      mem_ready = 1'b0;
      drive_req(4'd2, 5'd9, 1'b0, 1'b1, 5);
      #1;
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL mem_ack got=%b exp=1", wb_ack); end
      @(negedge clk); wb_req = 1'b0;
      repeat (3) @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk); #2;
      mem_ready = 1'b0;
      drain();
   endtask

   task automatic test_timeout();
      muldiv_busy = 1'b1;
      drive_req(4'd4, 5'd10, 1'b1, 1'b0, 17);
      #1;
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL to_ack got=%b exp=1", wb_ack); end
      @(negedge clk); wb_req = 1'b0;
      repeat (17) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cyc !== ack_cyc + 18) begin
         errors++; $display("FAIL to_busy_after got=%b cyc=%0d exp=0 cyc=%0d", busy, cyc, ack_cyc + 18);
      end
      muldiv_busy = 1'b0;
      drain();
   endtask

   task automatic test_illegal();
      drive_req(4'd13, 5'd4, 1'b1, 1'b0, 1);
      #1;
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL ill_ack got=%b exp=1", wb_ack); end
      @(negedge clk); #2; wb_req = 1'b0;
      drain();
   endtask

   task automatic test_zero_dst();
      drive_req(4'd8, 5'd0, 1'b0, 1'b0, 2);
      @(negedge clk); wb_req = 1'b0;
      drain();
   endtask

   task automatic test_back_to_back();
      drive_req(4'd7, 5'd5, 1'b0, 1'b1, 2);
      #1;
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack0 got=%b exp=1", wb_ack); end
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         if (i == 2) begin wb_src = 4'd10; wb_dst = 5'd17; end
         #1;
         checks++;
         if (wb_ack !== 1'b0) begin errors++; $display("FAIL b2b_busy_ack%0d got=%b exp=0", i, wb_ack); end
      end
      @(negedge clk);
      begin
         exp_t e;
         e.is_err = 1'b0; e.rw = 1'b1; e.src = 4'd10; e.dst = 5'd17; e.at = cyc + 2;
         sb.push_back(e);
      end
      #1;
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got=%b exp=1", wb_ack); end
      @(negedge clk); wb_req = 1'b0;
      drain();
   endtask

   task automatic test_flush_block();
      shift_done = 1'b0;
      drive_req(4'd3, 5'd12, 1'b0, 1'b0, -1);
      #1;
      checks++;
      if (wb_ack !== 1'b1) begin errors++; $display("FAIL fl_ack got=%b exp=1", wb_ack); end
      @(negedge clk);
      wb_src = 4'd6; #1;
      checks++;
      if (wb_ack !== 1'b0) begin errors++; $display("FAIL busy_ack got=%b exp=0", wb_ack); end
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; wb_req = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got busy=%b exp=0", busy); end
      wb_req = 1'b1; flush = 1'b1; #1;
      checks++;
      if (wb_ack !== 1'b0) begin errors++; $display("FAIL flush_idle_ack got=%b exp=0", wb_ack); end
      @(negedge clk);
      wb_req = 1'b0; flush = 1'b0; shift_done = 1'b1;
      repeat (4) @(negedge clk);
      shift_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush_stays_idle got busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_in_wait();
      mem_ready = 1'b0;
      drive_req(4'd0, 5'd3, 1'b0, 1'b0, -1);
      @(negedge clk); wb_req = 1'b0;
      #1; reset = 1'b1; #1;
      checks++;
      if ({busy, MemtoReg, WriteReg, RegWrite, wb_done, wb_err, wb_ack} !== 14'd0) begin
         errors++; $display("FAIL async_reset got=%h exp=0", {busy, MemtoReg, WriteReg, RegWrite, wb_done, wb_err, wb_ack});
      end
      mem_ready = 1'b1;
      @(negedge clk); reset = 1'b0;
      repeat (5) @(negedge clk);
      mem_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || WriteReg !== 5'd0) begin
         errors++; $display("FAIL post_reset got busy=%b dst=%0d exp 0 0", busy, WriteReg);
      end
   endtask

   initial begin
      test_reset();
      test_immediate();
      test_mem_wait();
      test_timeout();
      test_illegal();
      test_zero_dst();
      test_back_to_back();
      test_flush_block();
      test_reset_in_wait();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d exp=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
